// File: rtl/axi_ar_allocator_qos.sv
// axi_ar_allocator_qos: merges N AR channels into one registered AR output using QoS/round-robin arbitration.
// Each port has an outstanding-read limit; R-channel completions free up that port's slots again.
module axi_ar_allocator_qos #(
    parameter int AXI_ADDRESS_W   = 32,
    parameter int AXI_USER_W      = 6,
    parameter int N_TARG_PORT     = 7,
    parameter int LOG_N_TARG      = $clog2(N_TARG_PORT),
    parameter int AXI_ID_IN       = 16,
    parameter int AXI_ID_OUT      = AXI_ID_IN + LOG_N_TARG,
    parameter bit QOS_EN          = 1'b1,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_TARG_PORT*AXI_ID_IN-1:0]     arid_i,
    input  logic [N_TARG_PORT*AXI_ADDRESS_W-1:0] araddr_i,
    input  logic [N_TARG_PORT*8-1:0]             arlen_i,
    input  logic [N_TARG_PORT*3-1:0]             arsize_i,
    input  logic [N_TARG_PORT*2-1:0]             arburst_i,
    input  logic [N_TARG_PORT-1:0]               arlock_i,
    input  logic [N_TARG_PORT*4-1:0]             arcache_i,
    input  logic [N_TARG_PORT*3-1:0]             arprot_i,
    input  logic [N_TARG_PORT*4-1:0]             arregion_i,
    input  logic [N_TARG_PORT*AXI_USER_W-1:0]    aruser_i,
    input  logic [N_TARG_PORT*4-1:0]             arqos_i,
    input  logic [N_TARG_PORT-1:0]               arvalid_i,
    output logic [N_TARG_PORT-1:0]               arready_o,
    output logic [AXI_ID_OUT-1:0]                arid_o,
    output logic [AXI_ADDRESS_W-1:0]             araddr_o,
    output logic [7:0]                           arlen_o,
    output logic [2:0]                           arsize_o,
    output logic [1:0]                           arburst_o,
    output logic                                 arlock_o,
    output logic [3:0]                           arcache_o,
    output logic [2:0]                           arprot_o,
    output logic [3:0]                           arregion_o,
    output logic [AXI_USER_W-1:0]                aruser_o,
    output logic [3:0]                           arqos_o,
    output logic                                 arvalid_o,
    input  logic                                 arready_i,
    input  logic                                 rdone_valid_i,
    input  logic [LOG_N_TARG-1:0]                rdone_port_i,
    output logic [N_TARG_PORT-1:0]               busy_o
);
    logic [CNT_W-1:0]       cnt [N_TARG_PORT];
    logic [LOG_N_TARG-1:0]  ptr;
    logic [LOG_N_TARG-1:0]  win;
    logic [LOG_N_TARG-1:0]  sel;
    logic [N_TARG_PORT-1:0] elig;
    logic [N_TARG_PORT-1:0] cand;
    logic [3:0]             max_qos;
    logic                   found;
    logic                   load;
    logic                   any_elig;
    int                     idx;

    assign load      = !arvalid_o || arready_i;
    assign any_elig  = |elig;
    assign arready_o = (rst_n && load && any_elig) ? N_TARG_PORT'(1) << win : '0;

    always_comb begin
        max_qos = '0;
        cand    = '0;
        win     = '0;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int i = 0; i < N_TARG_PORT; i++)
            if (elig[i] && arqos_i[i*4 +: 4] > max_qos) max_qos = arqos_i[i*4 +: 4];
        for (int i = 0; i < N_TARG_PORT; i++)
            cand[i] = elig[i] && (!QOS_EN || arqos_i[i*4 +: 4] == max_qos);
        // first candidate at or after the pointer, wrapping explicitly for non-power-of-2 N
        for (int k = 0; k < N_TARG_PORT; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_TARG_PORT) idx = idx - N_TARG_PORT;
            sel = LOG_N_TARG'(idx);
            if (!found && cand[sel]) begin
                found = 1'b1;
                win   = sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid_o  <= 1'b0;
            ptr        <= '0;
            arid_o     <= '0;
            araddr_o   <= '0;
            arlen_o    <= '0;
            arsize_o   <= '0;
            arburst_o  <= '0;
            arlock_o   <= 1'b0;
            arcache_o  <= '0;
            arprot_o   <= '0;
            arregion_o <= '0;
            aruser_o   <= '0;
            arqos_o    <= '0;
        end else if (load) begin
            arvalid_o <= any_elig;
            if (any_elig) begin
                ptr        <= (win == LOG_N_TARG'(N_TARG_PORT - 1)) ? '0 : win + 1'b1;
                arid_o     <= {win, arid_i[win*AXI_ID_IN +: AXI_ID_IN]};
                araddr_o   <= araddr_i[win*AXI_ADDRESS_W +: AXI_ADDRESS_W];
                arlen_o    <= arlen_i[win*8 +: 8];
                arsize_o   <= arsize_i[win*3 +: 3];
                arburst_o  <= arburst_i[win*2 +: 2];
                arlock_o   <= arlock_i[win];
                arcache_o  <= arcache_i[win*4 +: 4];
                arprot_o   <= arprot_i[win*3 +: 3];
                arregion_o <= arregion_i[win*4 +: 4];
                aruser_o   <= aruser_i[win*AXI_USER_W +: AXI_USER_W];
                arqos_o    <= arqos_i[win*4 +: 4];
            end
        end
    end

    for (genvar g = 0; g < N_TARG_PORT; g++) begin : g_cnt
        logic inc, dec;
        assign inc       = arready_o[g];
        assign dec       = rdone_valid_i && rdone_port_i == LOG_N_TARG'(g) && cnt[g] != '0;
        assign busy_o[g] = cnt[g] == CNT_W'(MAX_OUTSTANDING);
        assign elig[g]   = arvalid_i[g] && cnt[g] < CNT_W'(MAX_OUTSTANDING);
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt[g] <= '0;
            else if (inc && !dec) cnt[g] <= cnt[g] + 1'b1;
            else if (dec && !inc) cnt[g] <= cnt[g] - 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_ar_allocator_qos.sv
// tb_axi_ar_allocator_qos: directed stimulus with a queue of expected grant ports; a monitor
// checks each output beat against the fixed per-port payload pattern.
module tb_axi_ar_allocator_qos;
    localparam int N = 7;
    localparam int AW = 32;
    localparam int UW = 6;
    localparam int LG = 3;
    localparam int IDI = 16;
    localparam int IDO = IDI + LG;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*IDI-1:0] arid_i;
    logic [N*AW-1:0] araddr_i;
    logic [N*8-1:0]  arlen_i;
    logic [N*3-1:0]  arsize_i;
    logic [N*2-1:0]  arburst_i;
    logic [N-1:0]    arlock_i;
    logic [N*4-1:0]  arcache_i;
    logic [N*3-1:0]  arprot_i;
    logic [N*4-1:0]  arregion_i;
    logic [N*UW-1:0] aruser_i;
    logic [N*4-1:0]  arqos_i;
    logic [N-1:0]    arvalid_i;
    logic [N-1:0]    arready_o;
    logic [IDO-1:0]  arid_o;
    logic [AW-1:0]   araddr_o;
    logic [7:0]      arlen_o;
    logic [2:0]      arsize_o;
    logic [1:0]      arburst_o;
    logic            arlock_o;
    logic [3:0]      arcache_o;
    logic [2:0]      arprot_o;
    logic [3:0]      arregion_o;
    logic [UW-1:0]   aruser_o;
    logic [3:0]      arqos_o;
    logic            arvalid_o;
    logic            arready_i;
    logic            rdone_valid_i;
    logic [LG-1:0]   rdone_port_i;
    logic [N-1:0]    busy_o;

    int total = 0;
    int bad = 0;
    int exp_q[$];

    axi_ar_allocator_qos #(
        .AXI_ADDRESS_W(AW), .AXI_USER_W(UW), .N_TARG_PORT(N), .AXI_ID_IN(IDI),
        .QOS_EN(1'b1), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
        .arburst_i(arburst_i), .arlock_i(arlock_i), .arcache_i(arcache_i), .arprot_i(arprot_i),
        .arregion_i(arregion_i), .aruser_i(aruser_i), .arqos_i(arqos_i), .arvalid_i(arvalid_i),
        .arready_o(arready_o), .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o),
        .arsize_o(arsize_o), .arburst_o(arburst_o), .arlock_o(arlock_o), .arcache_o(arcache_o),
        .arprot_o(arprot_o), .arregion_o(arregion_o), .aruser_o(aruser_o), .arqos_o(arqos_o),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .rdone_valid_i(rdone_valid_i),
        .rdone_port_i(rdone_port_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [IDO-1:0] exp_id(int p);
        logic [LG-1:0] pi;
        pi = LG'(p);
        return {pi, 16'(32'h00A0 + p)};
    endfunction

    function automatic logic [AW-1:0] exp_addr(int p);
        return 32'h4000_0000 + 32'(p) * 32'h100;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // every output handshake must match the next expected port's payload
    always @(negedge clk) begin
        if (rst_n && arvalid_o && arready_i) begin
            if (exp_q.size() == 0) chk("unexpected_beat", 64'(arid_o), 64'h7FFFF);
            else begin
                int p;
                p = exp_q.pop_front();
                chk("mon_id", 64'(arid_o), 64'(exp_id(p)));
                chk("mon_addr", 64'(araddr_o), 64'(exp_addr(p)));
                chk("mon_len", 64'(arlen_o), 64'(p + 1));
            end
        end
    end

    initial begin
        int seq[4];
        rst_n = 1'b0;
        arready_i = 1'b0;
        rdone_valid_i = 1'b0;
        rdone_port_i = '0;
        arqos_i = '0;
        arsize_i = '0;
        arburst_i = '0;
        arlock_i = '0;
        arcache_i = '0;
        arprot_i = '0;
        arregion_i = '0;
        aruser_i = '0;
        for (int p = 0; p < N; p++) begin
            arid_i[p*IDI +: IDI] = exp_id(p)[IDI-1:0];
            araddr_i[p*AW +: AW] = exp_addr(p);
            arlen_i[p*8 +: 8] = 8'(p + 1);
        end
        arvalid_i = '1;
        #12;
        chk("rst_arvalid", 64'(arvalid_o), 64'd0);
        chk("rst_arready", 64'(arready_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_araddr", 64'(araddr_o), 64'd0);
        chk("rst_arid", 64'(arid_o), 64'd0);
        arvalid_i = '0;
        @(negedge clk) rst_n = 1'b1;
        tick;

        // round-robin among equal-qos ports 0,1,2
        arready_i = 1'b1;
        arvalid_i = 7'b0000111;
        #1;
        chk("rr_lat0_arvalid", 64'(arvalid_o), 64'd0);
        for (int c = 0; c < 6; c++) begin
            chk("rr_arready", 64'(arready_o), 64'(7'b1 << (c % 3)));
            exp_q.push_back(c % 3);
            tick;
            if (c == 0) chk("rr_lat1_arvalid", 64'(arvalid_o), 64'd1);
        end
        chk("rr_busy", 64'(busy_o), 64'b0000111);
        chk("rr_all_busy_arready", 64'(arready_o), 64'd0);
        arvalid_i = '0;
        tick;
        tick;

        // port0 at limit is stalled while port3 is granted
        arvalid_i = 7'b0001001;
        #1;
        chk("lim_port3", 64'(arready_o), 64'b0001000);
        exp_q.push_back(3);
        tick;
        arvalid_i = 7'b0000001;
        #1;
        chk("lim_stall0", 64'(arready_o), 64'd0);
        rdone_valid_i = 1'b1;
        rdone_port_i = 3'd0;
        #1;
        chk("lim_rdone_same_cycle", 64'(arready_o), 64'd0);
        tick;
        rdone_valid_i = 1'b0;
        #1;
        chk("lim_unbusy0", 64'(busy_o[0]), 64'd0);
        chk("lim_regrant0", 64'(arready_o), 64'b0000001);
        rdone_valid_i = 1'b1;
        exp_q.push_back(0);
        tick;
        arvalid_i = 7'b0001000;
        rdone_port_i = 3'd3;
        #1;
        chk("incdec_port3", 64'(arready_o), 64'b0001000);
        exp_q.push_back(3);
        tick;
        arvalid_i = 7'b1000000;
        rdone_port_i = 3'd6;
        #1;
        chk("dec_at0_port6", 64'(arready_o), 64'b1000000);
        exp_q.push_back(6);
        tick;
        rdone_port_i = 3'd7;
        arvalid_i = 7'b0001001;
        #1;
        chk("bad_port_rdone_grant0", 64'(arready_o), 64'b0000001);
        exp_q.push_back(0);
        tick;
        rdone_valid_i = 1'b0;
        #1;
        chk("grant3_again", 64'(arready_o), 64'b0001000);
        exp_q.push_back(3);
        tick;
        chk("cnt_busy_map", 64'(busy_o), 64'b0001111);
        chk("cnt_all_busy_arready", 64'(arready_o), 64'd0);
        arvalid_i = '0;
        tick;
        tick;

        // qos priority: ports 4,5 (qos 9) beat port1 (qos 3)
        @(negedge clk) rst_n = 1'b0;
        #1 rst_n = 1'b1;
        tick;
        chk("qos_rst_busy", 64'(busy_o), 64'd0);
        arqos_i[1*4 +: 4] = 4'd3;
        arqos_i[4*4 +: 4] = 4'd9;
        arqos_i[5*4 +: 4] = 4'd9;
        arvalid_i = 7'b0110010;
        seq = '{4, 5, 4, 5};
        foreach (seq[c]) begin
            #1;
            chk("qos_arready", 64'(arready_o), 64'(7'b1 << seq[c]));
            exp_q.push_back(seq[c]);
            tick;
        end
        arvalid_i = 7'b0000010;
        #1;
        chk("qos_port1_late", 64'(arready_o), 64'b0000010);
        exp_q.push_back(1);
        tick;
        arvalid_i = '0;
        tick;

        // backpressure: output held for 5 cycles, next grant on drain cycle
        arready_i = 1'b0;
        arvalid_i = 7'b0001100;
        #1;
        chk("bp_grant2", 64'(arready_o), 64'b0000100);
        exp_q.push_back(2);
        tick;
        for (int c = 0; c < 5; c++) begin
            chk("bp_arvalid", 64'(arvalid_o), 64'd1);
            chk("bp_arready", 64'(arready_o), 64'd0);
            chk("bp_araddr", 64'(araddr_o), 64'(exp_addr(2)));
            chk("bp_arid", 64'(arid_o), 64'(exp_id(2)));
            tick;
        end
        arready_i = 1'b1;
        #1;
        chk("bp_drain_grant3", 64'(arready_o), 64'b0001000);
        exp_q.push_back(3);
        tick;
        arvalid_i = '0;
        tick;

        // async reset while stalled drops the pending beat
        arready_i = 1'b0;
        arvalid_i = 7'b1000001;
        #1;
        chk("rs_grant6", 64'(arready_o), 64'b1000000);
        tick;
        chk("rs_held", 64'(arvalid_o), 64'd1);
        tick;
        #2 rst_n = 1'b0;
        #1;
        chk("rs_arvalid", 64'(arvalid_o), 64'd0);
        chk("rs_busy", 64'(busy_o), 64'd0);
        chk("rs_arready", 64'(arready_o), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rs_first_lowest", 64'(arready_o), 64'b0000001);
        exp_q.push_back(0);
        arready_i = 1'b1;
        tick;
        arvalid_i = '0;
        tick;
        tick;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_ar_allocator_qos.md
Name: axi_ar_allocator_qos

Overview:
Next-generation AXI read-address allocator for the axi_node. It merges N_TARG_PORT slave-side AR channels into one master-side AR channel, and its arbiter is written inside the block. Compared with the previous allocator it adds:
- selectable round-robin or QoS-priority arbitration;
- a registered output stage for timing closure;
- per-port outstanding-read limiting, fed back from R-channel completion.
The outgoing ID is extended with the source port index, which R routing uses.

Parameters:
AXI_ADDRESS_W, 32, address width
AXI_USER_W, 6, user width
N_TARG_PORT, 7, number of input ports (>=2)
LOG_N_TARG, $clog2(N_TARG_PORT), port index width
AXI_ID_IN, 16, input ID width
AXI_ID_OUT, AXI_ID_IN+LOG_N_TARG, output ID width
QOS_EN, 1, 1=QoS-priority with round-robin tie-break; 0=pure round-robin
MAX_OUTSTANDING, 8, max in-flight reads per port (>=1)
CNT_W, $clog2(MAX_OUTSTANDING+1), counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
arid_i  in  N_TARG_PORT*AXI_ID_IN  packed per-port IDs
araddr_i  in  N_TARG_PORT*AXI_ADDRESS_W  addresses
arlen_i  in  N_TARG_PORT*8  burst lengths
arsize_i  in  N_TARG_PORT*3  sizes
arburst_i  in  N_TARG_PORT*2  burst types
arlock_i  in  N_TARG_PORT  lock
arcache_i  in  N_TARG_PORT*4  cache
arprot_i  in  N_TARG_PORT*3  prot
arregion_i  in  N_TARG_PORT*4  region
aruser_i  in  N_TARG_PORT*AXI_USER_W  user
arqos_i  in  N_TARG_PORT*4  qos
arvalid_i  in  N_TARG_PORT  valid
arready_o  out  N_TARG_PORT  ready (one-hot or zero)
arid_o  out  AXI_ID_OUT  {port index, arid}
araddr_o, arlen_o, arsize_o, arburst_o, arlock_o, arcache_o, arprot_o, arregion_o, aruser_o, arqos_o  out  single-port widths  forwarded fields
arvalid_o  out  1  valid
arready_i  in  1  ready
rdone_valid_i  in  1  pulse: one read burst completed (RLAST handshake)
rdone_port_i  in  LOG_N_TARG  port whose burst completed
busy_o  out  N_TARG_PORT  per-port "at outstanding limit" flag

Behaviour:
- Reset (rst_n low, async):
  - arvalid_o=0 and all payload registers 0.
  - Round-robin pointer=0.
  - All counters=0, so busy_o=0.
  - arready_o=0 while in reset.
- Eligibility: port i is eligible when arvalid_i[i]=1 and cnt[i]<MAX_OUTSTANDING. busy_o[i]=(cnt[i]==MAX_OUTSTANDING).
- Load condition: load = !arvalid_o | arready_i (output register empty, or draining this cycle).
- Arbitration (combinational, evaluated every cycle):
  - QOS_EN=1: the candidate set is eligible ports whose arqos equals the maximum arqos among eligible ports.
  - QOS_EN=0: the candidate set is all eligible ports.
  - The winner is the first candidate at or after the pointer, scanning upward with wrap.
- arready_o[i]=load & winner[i] & any_eligible. arready_o is combinational from registers and arvalid_i. It never depends on arready_o itself.
- On input handshake (arready_o[w]=1):
  - Output register captures port w's fields and arid_o={w[LOG_N_TARG-1:0], arid_i[w]}.
  - arvalid_o<=1.
  - pointer<=(w+1) mod N_TARG_PORT; the wrap is explicit, so a non-power-of-2 N never yields an invalid index.
- On load with no eligible port: arvalid_o<=0, pointer unchanged, payload retained.
- Latency: one cycle from an accepted arvalid_i to arvalid_o. Full throughput (one AR per cycle) while arready_i=1.
- Output stability: while arvalid_o=1 and arready_i=0, all output fields are held stable and no arready_o is asserted.
- Counter cnt[i]:
  - +1 on input handshake of port i.
  - -1 on rdone_valid_i with rdone_port_i==i.
  - Both in the same cycle: unchanged.
  - Decrement at 0 is ignored (saturates). rdone_port_i>=N_TARG_PORT is ignored.
  - The counter never exceeds MAX_OUTSTANDING because eligibility masks the port.
- A port at the limit with arvalid_i high is stalled without blocking other ports. It becomes eligible in the cycle after a decrement.
- Reset mid-transfer drops any pending output beat immediately. No recovery of in-flight counts.

Test Plan:
- Round-robin fairness: QOS_EN=0, N=3, ports 0,1,2 always valid, arready_i=1 -> arid_o upper bits sequence 0,1,2,0,1,2; one arready_o per cycle; arvalid_o first high one cycle after arvalid_i.
- QoS priority: QOS_EN=1, port1 qos=3, port4 qos=9, port5 qos=9, pointer 0 -> grants alternate 4,5,4,5; port1 starves until ports 4 and 5 drop valid, then is granted.
- Backpressure: single grant, arready_i=0 for 5 cycles -> araddr_o/arid_o stable, arvalid_o=1, arready_o=0 throughout; transfer completes on the cycle arready_i=1, with the next grant in that same cycle.
- Outstanding limit: MAX_OUTSTANDING=2, port0 issues 2 reads with no rdone -> busy_o[0]=1, port0 stalled while port2 is still granted; one rdone_valid_i with port 0 -> port0 granted the next cycle.
- Simultaneous inc/dec: port3 at cnt=1 handshakes in the same cycle as rdone for port3 -> cnt stays 1; rdone for port6 at cnt=0 -> cnt stays 0.
- Async reset mid-stall: assert rst_n=0 while arvalid_o=1 and arready_i=0 -> arvalid_o=0 immediately, counters 0; after release, first grant goes to the lowest valid port.
